imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles little-endian bytes into 32-bit
// words, writes them at consecutive PC addresses and holds the core in reset meanwhile.
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [5:0]  Word_Count,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        Wr_En,
  output logic [31:0] Wr_Addr,
  output logic [31:0] Wr_Data,
  output logic        Busy,
  output logic        Cpu_Hold,
  output logic        Done,
  output logic        Err
);

  // state  | meaning
  // IDLE   | waiting for Start, core released
  // RECV   | collecting the 4 bytes of the current word
  // WRITE  | one-cycle memory write of the assembled word
  // FINISH | one-cycle Done pulse before releasing the core
  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  localparam int IW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   asm_q, asm_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          ready_q, ready_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;

  assign accept = Byte_Valid && ready_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    idle_d  = idle_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RECV;
          if (Word_Count == 6'd0 || int'(Word_Count) > DEPTH) n_d = IW'(DEPTH);
          else                                                n_d = IW'(Word_Count);
          widx_d = '0;
          bidx_d = '0;
          err_d  = 1'b0;
          idle_d = TW'(TIMEOUT - 1);
        end
      end
      RECV: begin
        if (accept) begin
          idle_d = TW'(TIMEOUT - 1);
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: asm_d[7:0]   = Byte_In;
            2'd1: asm_d[15:8]  = Byte_In;
            2'd2: asm_d[23:16] = Byte_In;
            default: begin
              state_d = WRITE;
              wr_en_d = 1'b1;
              addr_d  = BASE_ADDR + (32'(widx_q) << 2);
              data_d  = {Byte_In, asm_q};
            end
          endcase
        end else if (idle_q == '0) begin
          // partial word is dropped; earlier words stay in memory
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_q - TW'(1);
        end
      end
      WRITE: begin
        if (widx_q == n_q - IW'(1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = RECV;
          widx_d  = widx_q + IW'(1);
          bidx_d  = '0;
          idle_d  = TW'(TIMEOUT - 1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RECV);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      idle_q  <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      idle_q  <= idle_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Byte_Ready = ready_q;
  assign Wr_En      = wr_en_q;
  assign Wr_Addr    = addr_q;
  assign Wr_Data    = data_q;
  assign Busy       = busy_q;
  assign Cpu_Hold   = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load vectors plus hand sequences for
// timeout, Start-while-busy and reset mid-load.
module tb_imem_loader;
  logic        clk, rst_n, Start, Byte_Valid;
  logic [5:0]  Word_Count;
  logic [7:0]  Byte_In;
  logic        Byte_Ready, Wr_En, Busy, Cpu_Hold, Done, Err;
  logic [31:0] Wr_Addr, Wr_Data;

  int total, bad;
  int cyc, done_cnt, done_cyc, last_wr_cyc;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [5:0]  wc;
    int          gap_max;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vecs[7];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Word_Count(Word_Count),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Busy(Busy),
    .Cpu_Hold(Cpu_Hold), .Done(Done), .Err(Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (Wr_En === 1'b1) begin
      wa_q.push_back(Wr_Addr);
      wd_q.push_back(Wr_Data);
      last_wr_cyc = cyc;
    end
    if (Done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int v, input int i);
    if (v == 0) return 32'h02A0_0093;
    if (v == 1) begin
      if (i == 0) return 32'h0000_007F;
      if (i == 1) return 32'h02A0_0093;
      return 32'h0100_0113;
    end
    return {8'(v), 8'(i), 8'(i * 7 + 1), 8'h13};
  endfunction

  // called at a negedge, returns at a negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    Byte_Valid = 1'b0;
    repeat (gap) @(negedge clk);
    Byte_In    = b;
    Byte_Valid = 1'b1;
    guard = 0;
    while (Byte_Ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("byte_ready_wait", 32'(Byte_Ready), 32'd1);
    @(negedge clk);
    Byte_Valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], int'($urandom_range(gap_max, 0)));
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (Busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (Busy !== 1'b0) chk("busy_release_wait", 32'(Busy), 32'd0);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt    = 0;
    done_cyc    = -100;
    last_wr_cyc = -200;
  endtask

  task automatic run_load(input int v);
    int k;
    clear_mon();
    Start      = 1'b1;
    Word_Count = vecs[v].wc;
    @(negedge clk);
    Start = 1'b0;
    chk($sformatf("v%0d busy_after_start", v), 32'(Busy), 32'd1);
    chk($sformatf("v%0d err_cleared", v), 32'(Err), 32'd0);
    for (int i = 0; i < vecs[v].exp_n; i++) send_word(exp_word(v, i), vecs[v].gap_max);
    wait_idle(k);
    chk($sformatf("v%0d nwrites", v), 32'(wa_q.size()), 32'(vecs[v].exp_n));
    for (int i = 0; i < wa_q.size() && i < vecs[v].exp_n; i++) begin
      chk($sformatf("v%0d addr[%0d]", v, i), wa_q[i], 32'(i * 4));
      chk($sformatf("v%0d data[%0d]", v, i), wd_q[i], exp_word(v, i));
    end
    chk($sformatf("v%0d done_cnt", v), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d done_after_write", v), 32'(done_cyc), 32'(last_wr_cyc + 1));
    chk($sformatf("v%0d cpu_hold", v), 32'(Cpu_Hold), 32'd0);
    chk($sformatf("v%0d err", v), 32'(Err), 32'd0);
    chk($sformatf("v%0d addr_hold", v), Wr_Addr, vecs[v].exp_last);
    chk($sformatf("v%0d data_hold", v), Wr_Data, exp_word(v, vecs[v].exp_n - 1));
  endtask

  initial begin
    int k;
    total = 0; bad = 0; cyc = 0;
    clear_mon();
    vecs[0] = '{wc: 6'd1,  gap_max: 0, exp_n: 1,  exp_last: 32'h00};
    vecs[1] = '{wc: 6'd3,  gap_max: 5, exp_n: 3,  exp_last: 32'h08};
    vecs[2] = '{wc: 6'd0,  gap_max: 1, exp_n: 32, exp_last: 32'h7C};
    vecs[3] = '{wc: 6'd40, gap_max: 0, exp_n: 32, exp_last: 32'h7C};
    vecs[4] = '{wc: 6'd32, gap_max: 0, exp_n: 32, exp_last: 32'h7C};
    vecs[5] = '{wc: 6'd33, gap_max: 0, exp_n: 32, exp_last: 32'h7C};
    vecs[6] = '{wc: 6'd31, gap_max: 2, exp_n: 31, exp_last: 32'h78};

    rst_n = 1'b1; Start = 1'b0; Word_Count = '0; Byte_In = '0; Byte_Valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst byte_ready", 32'(Byte_Ready), 32'd0);
    chk("rst wr_en", 32'(Wr_En), 32'd0);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst cpu_hold", 32'(Cpu_Hold), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst err", 32'(Err), 32'd0);
    chk("rst wr_addr", Wr_Addr, 32'h0);
    chk("rst wr_data", Wr_Data, 32'h0);
    repeat (2) @(negedge clk);

    // release and Start together: first edge after release must take the Start
    rst_n = 1'b1;
    for (int v = 0; v < 7; v++) run_load(v);

    // two bytes then silence
    clear_mon();
    Start = 1'b1; Word_Count = 6'd2;
    @(negedge clk);
    Start = 1'b0;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    wait_idle(k);
    chk("to idle_cycles", 32'(k), 32'd1024);
    chk("to err", 32'(Err), 32'd1);
    chk("to nwrites", 32'(wa_q.size()), 32'd0);
    chk("to done_cnt", 32'(done_cnt), 32'd0);
    chk("to cpu_hold", 32'(Cpu_Hold), 32'd0);
    chk("to byte_ready", 32'(Byte_Ready), 32'd0);
    run_load(0);

    // Start pulsed mid-load must not restart or resize it
    clear_mon();
    Start = 1'b1; Word_Count = 6'd2;
    @(negedge clk);
    Start = 1'b0;
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    Start = 1'b1; Word_Count = 6'd5;
    @(negedge clk);
    Start = 1'b0;
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_word(32'h1234_5678, 1);
    wait_idle(k);
    chk("sib nwrites", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("sib addr0", wa_q[0], 32'h0);
      chk("sib data0", wd_q[0], 32'hDEAD_BEEF);
      chk("sib addr1", wa_q[1], 32'h4);
      chk("sib data1", wd_q[1], 32'h1234_5678);
    end
    chk("sib done_cnt", 32'(done_cnt), 32'd1);

    // reset in the middle of the third word
    clear_mon();
    Start = 1'b1; Word_Count = 6'd3;
    @(negedge clk);
    Start = 1'b0;
    send_word(32'h0A0B_0C0D, 0);
    send_word(32'h5566_7788, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("mid pre_addr", Wr_Addr, 32'h4);
    Byte_In = 8'h03; Byte_Valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid byte_ready", 32'(Byte_Ready), 32'd0);
    chk("mid busy", 32'(Busy), 32'd0);
    chk("mid cpu_hold", 32'(Cpu_Hold), 32'd0);
    chk("mid wr_addr", Wr_Addr, 32'h0);
    chk("mid wr_data", Wr_Data, 32'h0);
    clear_mon();
    Byte_Valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    Byte_Valid = 1'b1;
    repeat (10) @(negedge clk);
    Byte_Valid = 1'b0;
    chk("post_rst nwrites", 32'(wa_q.size()), 32'd0);
    chk("post_rst done_cnt", 32'(done_cnt), 32'd0);
    chk("post_rst busy", 32'(Busy), 32'd0);
    chk("post_rst byte_ready", 32'(Byte_Ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
